pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its high and low durations in `clkin` cycles. It is the receive-side counterpart of the `pwm` generator: `pwm` turns an on/off period pair into a waveform, and `pwm_capture` recovers the pair from a waveform. It sits on a Bus Pirate IO pin for frequency and duty-cycle measurement. It can also be looped back to a `pwm` instance for self-test.

---
 rtl/pwm_capture.sv | 151 +++++++++++++++
 tb/tb_pwm_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and reports its high and
// low durations in clkin cycles.
//
// Ports:
//   clkin     - system clock, all state changes on the rising edge
//   rst       - synchronous active-low reset
//   en        - capture enable; low forces IDLE, results hold
//   sigin     - asynchronous PWM input
//   onperiod  - last measured high time (cycles)
//   offperiod - last measured low time (cycles)
//   valid     - one-cycle pulse when onperiod/offperiod update
//   ovf       - a counter of the reported measurement saturated
//   timeout   - level, high while the active phase counter is saturated
module pwm_capture #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sigin,
  output logic [WIDTH-1:0] onperiod,
  output logic [WIDTH-1:0] offperiod,
  output logic             valid,
  output logic             ovf,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitRise,
    StMeasHigh,
    StMeasLow
  } state_e;

  state_e           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] lcnt;
  logic             ovf_acc;  // saturation seen during the current high+low pair

  logic             rise;
  logic             fall;
  logic             hcnt_at_max;
  logic             lcnt_at_max;
  logic             hcnt_to_max;
  logic             lcnt_to_max;

  // Both edges come from the same s2/s3 pair, so high and low times see
  // identical synchronizer delay and a high of N samples reports exactly N.
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Counter is already saturated, or its next increment saturates it.
  assign hcnt_at_max = (hcnt == CntMax);
  assign lcnt_at_max = (lcnt == CntMax);
  assign hcnt_to_max = (hcnt == (CntMax - CntOne));
  assign lcnt_to_max = (lcnt == (CntMax - CntOne));

  always_ff @(posedge clkin) begin
    if (!rst) begin
      state     <= StIdle;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      hcnt      <= '0;
      lcnt      <= '0;
      ovf_acc   <= 1'b0;
      onperiod  <= '0;
      offperiod <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      s1      <= sigin;
      s2      <= s1;
      s3      <= s2;
      valid   <= 1'b0;
      timeout <= 1'b0;

      if (!en) begin
        state   <= StIdle;
        hcnt    <= '0;
        lcnt    <= '0;
        ovf_acc <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            state <= StWaitRise;
          end

          // The period in progress at enable is partial, so measurement
          // only starts on the first rise seen here.
          StWaitRise: begin
            if (rise) begin
              state   <= StMeasHigh;
              hcnt    <= CntOne;
              ovf_acc <= 1'b0;
            end
          end

          StMeasHigh: begin
            if (fall) begin
              state <= StMeasLow;
              lcnt  <= CntOne;
            end else if (hcnt_at_max) begin
              timeout <= 1'b1;
            end else begin
              hcnt <= hcnt + CntOne;
              if (hcnt_to_max) begin
                ovf_acc <= 1'b1;
                timeout <= 1'b1;
              end
            end
          end

          // A rise wins over saturation: the period is still reported and
          // ovf_acc already carries the saturation.
          StMeasLow: begin
            if (rise) begin
              onperiod  <= hcnt;
              offperiod <= lcnt;
              ovf       <= ovf_acc;
              valid     <= 1'b1;
              state     <= StMeasHigh;
              hcnt      <= CntOne;
              ovf_acc   <= 1'b0;
            end else if (lcnt_at_max) begin
              timeout <= 1'b1;
            end else begin
              lcnt <= lcnt + CntOne;
              if (lcnt_to_max) begin
                ovf_acc <= 1'b1;
                timeout <= 1'b1;
              end
            end
          end

          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (WIDTH = 4): a table of reset/start-up vectors,
// directed corner sequences and randomized waveforms, all checked every cycle
// against a run-length reference model.
module tb_pwm_capture;

  localparam int unsigned W   = 4;
  localparam int          MAX = (1 << W) - 1;

  logic         clkin;
  logic         rst;
  logic         en;
  logic         sigin;
  logic [W-1:0] onperiod;
  logic [W-1:0] offperiod;
  logic         valid;
  logic         ovf;
  logic         timeout;

  pwm_capture #(.WIDTH(W)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .en       (en),
    .sigin    (sigin),
    .onperiod (onperiod),
    .offperiod(offperiod),
    .valid    (valid),
    .ovf      (ovf),
    .timeout  (timeout)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Captured DUT reports.
  int nvalid   = 0;
  int last_on  = 0;
  int last_off = 0;
  int last_ovf = 0;

  // Loopback bookkeeping.
  int lb_on    = -1;
  int lb_off   = -1;
  int lb_match = 0;

  // Reference model: the input seen two/three clocks late, a phase tracker
  // and unbounded run lengths that are clipped only when reported.
  logic hist[3];
  int   m_mode;  // 0 idle, 1 waiting for first rise, 2 in high run, 3 in low run
  int   hl;
  int   ll;
  int   m_valid, m_on, m_off, m_ovf, m_to;

  function automatic int clip(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic x);
    logic rs, fl;
    if (!r) begin
      for (int i = 0; i < 3; i++) hist[i] = 1'b0;
      m_mode = 0; hl = 0; ll = 0;
      m_valid = 0; m_on = 0; m_off = 0; m_ovf = 0; m_to = 0;
      return;
    end
    rs = hist[1] & ~hist[2];
    fl = ~hist[1] & hist[2];
    m_valid = 0;
    if (!e) begin
      m_mode = 0; hl = 0; ll = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rs) begin m_mode = 2; hl = 1; end
    end else if (m_mode == 2) begin
      if (fl) begin m_mode = 3; ll = 1; end
      else hl++;
    end else begin
      if (rs) begin
        m_valid = 1;
        m_on    = clip(hl);
        m_off   = clip(ll);
        m_ovf   = (hl >= MAX || ll >= MAX) ? 1 : 0;
        m_mode  = 2;
        hl      = 1;
      end else begin
        ll++;
      end
    end
    m_to = ((m_mode == 2 && hl >= MAX) || (m_mode == 3 && ll >= MAX)) ? 1 : 0;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the falling edge: drive, clock, update the model, compare.
  task automatic step(input logic r, input logic e, input logic x);
    rst   = r;
    en    = e;
    sigin = x;
    @(posedge clkin);
    cyc++;
    model_step(r, e, x);
    #1;
    check("valid",     int'(valid),     m_valid);
    check("onperiod",  int'(onperiod),  m_on);
    check("offperiod", int'(offperiod), m_off);
    check("ovf",       int'(ovf),       m_ovf);
    check("timeout",   int'(timeout),   m_to);
    if (valid) begin
      nvalid++;
      last_on  = int'(onperiod);
      last_off = int'(offperiod);
      last_ovf = int'(ovf);
      if (int'(onperiod) == lb_on && int'(offperiod) == lb_off) lb_match++;
    end
    @(negedge clkin);
  endtask

  task automatic run_level(input logic x, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, x);
  endtask

  task automatic run_pwm(input int on_c, input int off_c, input int periods);
    for (int p = 0; p < periods; p++) begin
      run_level(1'b1, on_c);
      run_level(1'b0, off_c);
    end
  endtask

  typedef struct {
    logic r;
    logic e;
    logic x;
    int   v;
    int   on;
    int   off;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    int lb_set[3][2];

    // Reset held for three cycles with sigin toggling, then 2 high / 1 low.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    for (int i = 3; i < 15; i++) begin
      tbl[i].r   = 1'b1;
      tbl[i].e   = 1'b1;
      tbl[i].x   = ((i - 3) % 3) != 2;
      tbl[i].v   = (i >= 8 && ((i - 8) % 3) == 0) ? 1 : 0;
      tbl[i].on  = (i >= 8) ? 2 : 0;
      tbl[i].off = (i >= 8) ? 1 : 0;
    end

    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    m_mode = 0; hl = 0; ll = 0;
    m_valid = 0; m_on = 0; m_off = 0; m_ovf = 0; m_to = 0;

    rst = 1'b0; en = 1'b0; sigin = 1'b0;
    @(negedge clkin);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].x);
      check("tbl_valid", int'(valid),     tbl[i].v);
      check("tbl_on",    int'(onperiod),  tbl[i].on);
      check("tbl_off",   int'(offperiod), tbl[i].off);
      check("tbl_ovf",   int'(ovf),       0);
    end

    // Duty change mid-stream.
    run_pwm(2, 1, 3);
    run_pwm(1, 2, 4);
    check("duty_12_on", last_on, 1);
    check("duty_12_off", last_off, 2);
    run_pwm(7, 1, 4);
    check("duty_71_on", last_on, 7);
    check("duty_71_off", last_off, 1);

    // Saturating high time: 20 high, 3 low, then a rise.
    run_level(1'b1, 20);
    check("sat_timeout", int'(timeout), 1);
    run_level(1'b0, 3);
    vc = nvalid;
    run_level(1'b1, 4);
    check("sat_count", nvalid - vc, 1);
    check("sat_on", last_on, 15);
    check("sat_off", last_off, 3);
    check("sat_ovf", last_ovf, 1);
    run_level(1'b0, 2);
    vc = nvalid;
    run_level(1'b1, 3);
    check("post_sat_count", nvalid - vc, 1);
    check("post_sat_ovf", last_ovf, 0);
    check("post_sat_on", last_on, 4);

    // Stuck low for 2^W + 5 cycles.
    vc = nvalid;
    run_level(1'b0, MAX + 6);
    check("stuck_novalid", nvalid - vc, 0);
    check("stuck_timeout", int'(timeout), 1);
    run_level(1'b1, 3);
    check("stuck_count", nvalid - vc, 1);
    check("stuck_ovf", last_ovf, 1);
    check("stuck_off", last_off, 15);

    // Reset during a high phase.
    run_pwm(3, 3, 3);
    run_level(1'b1, 5);
    step(1'b0, 1'b1, 1'b1);
    check("rst_on", int'(onperiod), 0);
    check("rst_off", int'(offperiod), 0);
    check("rst_valid", int'(valid), 0);
    run_pwm(3, 3, 4);
    check("rst_after_on", last_on, 3);

    // Enable dropped for one cycle mid-period.
    run_pwm(3, 2, 3);
    run_level(1'b1, 2);
    step(1'b1, 1'b0, 1'b1);
    check("en_hold_on", int'(onperiod), 3);
    check("en_hold_off", int'(offperiod), 2);
    run_level(1'b1, 1);
    run_level(1'b0, 2);
    run_pwm(3, 2, 3);

    // Randomized waveforms with occasional enable drops and resets.
    begin
      logic lvl;
      lvl = 1'b0;
      for (int k = 0; k < 150; k++) begin
        int len;
        lvl = ~lvl;
        len = $urandom_range(20, 1);
        for (int j = 0; j < len; j++) begin
          step(($urandom_range(299, 0) != 0), ($urandom_range(49, 0) != 0), lvl);
        end
      end
    end

    // Loopback against an ideal generator at several settings.
    lb_set[0][0] = 1; lb_set[0][1] = 1;
    lb_set[1][0] = 3; lb_set[1][1] = 5;
    lb_set[2][0] = 6; lb_set[2][1] = 2;
    run_level(1'b0, 4);
    for (int s = 0; s < 3; s++) begin
      lb_on    = lb_set[s][0];
      lb_off   = lb_set[s][1];
      lb_match = 0;
      run_pwm(lb_on, lb_off, 13);
      check("loop_stable", (lb_match >= 10) ? 1 : 0, 1);
      check("loop_last_on", last_on, lb_on);
      check("loop_last_off", last_off, lb_off);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
